// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the front-panel units.
//   cpu_state_t   : CPU state codes driven by the controller (ST_IDLE/ST_LOAD/ST_CHECK/ST_RUN)
//   panel_state_t : panel entry FSM encodings (P_IDLE/P_WRITE/P_READ)
//   DEB_CYCLES_DEFAULT : debounce length used on the board clock
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'b00,
    P_WRITE = 2'b01,
    P_READ  = 2'b10
  } panel_state_t;

  localparam logic [19:0] DEB_CYCLES_DEFAULT = 20'd500000;

endpackage

// File: rtl/panel_input_if.sv
// panel_input_if: memory-side request/acknowledge bus of the front panel.
//   addr_out : current panel address (also shown as MAR)
//   data_out : write data, stable while mem_wr=1
//   mem_wr   : write request level, held until mem_ack
//   mem_rd   : read request level, held until mem_ack
//   mem_ack  : memory completed the current request
//   busy     : panel has a request outstanding
// Modports: master = panel side, slave = memory side.
interface panel_input_if;
  logic [7:0] addr_out;
  logic [7:0] data_out;
  logic       mem_wr;
  logic       mem_rd;
  logic       mem_ack;
  logic       busy;

  modport master (
    output addr_out, data_out, mem_wr, mem_rd, busy,
    input  mem_ack
  );

  modport slave (
    input  addr_out, data_out, mem_wr, mem_rd, busy,
    output mem_ack
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, debounce counter and press-pulse generator for one
// active-low pushbutton.
//   clk, rst : system clock, asynchronous active-high reset
//   key_n    : raw pushbutton (active-low, asynchronous)
//   press    : one-cycle pulse on an accepted released->pressed transition
// The debounced level changes on the edge where the synchronized key has disagreed with it
// for DEB_CYCLES consecutive edges; any agreeing sample restarts the count.
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic        sync1_r;
  logic        sync2_r;
  logic        level_r;
  logic        press_r;
  logic [19:0] cnt_r;
  logic        differ_s;
  logic        flip_s;

  // Detect disagreement and the edge on which the debounced level must flip.
  always_comb begin
    differ_s = (sync2_r != level_r);
    flip_s   = differ_s && (cnt_r == (DEB_CYCLES - 20'd1));
  end

  // Two-flop synchronizer; idles at released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter, debounced level and press pulse (only a 1->0 flip is an event).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 1'b1;
      cnt_r   <= 20'd0;
      press_r <= 1'b0;
    end else begin
      press_r <= flip_s && level_r;
      if (!differ_s) begin
        cnt_r <= 20'd0;
      end else if (flip_s) begin
        level_r <= sync2_r;
        cnt_r   <= 20'd0;
      end else begin
        cnt_r <= cnt_r + 20'd1;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/panel_input.sv
// panel_input: front-panel entry unit.
//   clk, rst    : system clock, asynchronous active-high reset
//   State       : CPU state from controller (00 IDLE, 01 LOAD, 10 CHECK, 11 RUN)
//   SW          : slide switches, address/data byte
//   key_addr_n  : pushbutton, loads SW into addr_out
//   key_step_n  : pushbutton, writes (LOAD) or reads (CHECK) at addr_out, then increments
//   bus         : memory request/ack bus (addr_out, data_out, mem_wr, mem_rd, mem_ack, busy)
// All bus outputs are registered. A transaction ends only on mem_ack or rst.
module panel_input
  import cpu_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          State,
  input  logic [7:0]          SW,
  input  logic                key_addr_n,
  input  logic                key_step_n,
  panel_input_if.master       bus
);

  panel_state_t state_r, state_n;
  logic [7:0]   addr_r, addr_n;
  logic [7:0]   data_r, data_n;
  logic         wr_r, wr_n;
  logic         rd_r, rd_n;
  logic         busy_r, busy_n;
  logic         addr_press_s;
  logic         step_press_s;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_addr (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_addr_n),
    .press (addr_press_s)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_step_n),
    .press (step_press_s)
  );

  // Next-state and next-output logic; presses outside IDLE are simply not looked at.
  always_comb begin
    state_n = state_r;
    addr_n  = addr_r;
    data_n  = data_r;
    wr_n    = wr_r;
    rd_n    = rd_r;
    case (state_r)
      P_IDLE: begin
        // Address press takes priority, so a simultaneous step press is dropped.
        if (addr_press_s && (State != ST_RUN)) begin
          addr_n = SW;
        end else if (step_press_s && (State == ST_LOAD)) begin
          data_n  = SW;
          wr_n    = 1'b1;
          state_n = P_WRITE;
        end else if (step_press_s && (State == ST_CHECK)) begin
          rd_n    = 1'b1;
          state_n = P_READ;
        end else begin
          state_n = P_IDLE;
        end
      end
      P_WRITE, P_READ: begin
        if (bus.mem_ack) begin
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          addr_n  = addr_r + 8'd1;
          state_n = P_IDLE;
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        state_n = P_IDLE;
      end
    endcase
    busy_n = (state_n != P_IDLE);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= P_IDLE;
      addr_r  <= 8'h00;
      data_r  <= 8'h00;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      addr_r  <= addr_n;
      data_r  <= data_n;
      wr_r    <= wr_n;
      rd_r    <= rd_n;
      busy_r  <= busy_n;
    end
  end

  assign bus.addr_out = addr_r;
  assign bus.data_out = data_r;
  assign bus.mem_wr   = wr_r;
  assign bus.mem_rd   = rd_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_panel_input.sv
// tb_panel_input: self-checking bench for panel_input with DEB_CYCLES=4.
// A memory responder records each new request into obs_q and acknowledges it ack_delay
// cycles later; tests push the transactions they expect into exp_q and compare both queues.
module tb_panel_input;
  import cpu_pkg::*;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       rst;
  logic [1:0] cpu_state;
  logic [7:0] sw;
  logic       key_addr_n;
  logic       key_step_n;

  int   checks;
  int   errors;
  int   ack_delay;
  int   wait_cnt;
  txn_t exp_q[$];
  txn_t obs_q[$];

  panel_input_if bus ();

  panel_input #(.DEB_CYCLES(20'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .State      (cpu_state),
    .SW         (sw),
    .key_addr_n (key_addr_n),
    .key_step_n (key_step_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: log each new request, raise ack for one cycle after ack_delay cycles.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack <= 1'b0;
      wait_cnt    <= 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
      wait_cnt    <= 0;
    end else if (bus.mem_wr || bus.mem_rd) begin
      if (wait_cnt == 0)
        obs_q.push_back(txn_t'{bus.mem_wr, bus.mem_rd, bus.addr_out, bus.data_out});
      wait_cnt <= wait_cnt + 1;
      if (wait_cnt + 1 >= ack_delay) bus.mem_ack <= 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addr_press(input logic [7:0] v);
    @(negedge clk);
    sw = v;
    key_addr_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_addr_n = 1'b1;
    cyc(10);
  endtask

  task automatic test_reset;
    cyc(3);
    checks++;
    if (bus.addr_out !== 8'h00 || bus.data_out !== 8'h00 || bus.mem_wr !== 1'b0 ||
        bus.mem_rd !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h data=%h wr=%b rd=%b busy=%b, want 00 00 0 0 0",
               bus.addr_out, bus.data_out, bus.mem_wr, bus.mem_rd, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_addr_load;
    @(negedge clk);
    sw = 8'h3C;
    key_addr_n = 1'b0;
    cyc(6);
    checks++;
    if (bus.addr_out !== 8'h00) begin
      errors++;
      $display("FAIL addr_early: got %h want 00", bus.addr_out);
    end
    cyc(1);
    checks++;
    if (bus.addr_out !== 8'h3C || bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL addr_load: addr=%h wr=%b rd=%b want 3c 0 0", bus.addr_out, bus.mem_wr, bus.mem_rd);
    end
    cyc(3);
    @(negedge clk);
    key_addr_n = 1'b1;
    cyc(10);
  endtask

  task automatic test_write_wrap;
    txn_t e, o;
    cpu_state = ST_LOAD;
    addr_press(8'hFF);
    @(negedge clk);
    sw = 8'hA5;
    exp_q.push_back(txn_t'{1'b1, 1'b0, 8'hFF, 8'hA5});
    key_step_n = 1'b0;
    cyc(7);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.data_out !== 8'hA5 || bus.addr_out !== 8'hFF || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL write_start: wr=%b data=%h addr=%h busy=%b want 1 a5 ff 1",
               bus.mem_wr, bus.data_out, bus.addr_out, bus.busy);
    end
    @(negedge clk);
    sw = 8'h5A;
    cyc(2);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL write_hold: wr=%b data=%h want 1 a5", bus.mem_wr, bus.data_out);
    end
    cyc(1);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.addr_out !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_done: wr=%b addr=%h busy=%b want 0 00 0", bus.mem_wr, bus.addr_out, bus.busy);
    end
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(10);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL write_count: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL write_txn: got %h want %h", o, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_bounce;
    txn_t e, o;
    @(negedge clk);
    sw = 8'h4D;
    for (int i = 0; i < 5; i++) begin
      key_step_n = 1'b0;
      repeat (2) @(negedge clk);
      key_step_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    cyc(8);
    checks++;
    if (obs_q.size() != 0 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL bounce_rejected: reqs=%0d wr=%b want 0 0", obs_q.size(), bus.mem_wr);
    end
    @(negedge clk);
    exp_q.push_back(txn_t'{1'b1, 1'b0, 8'h00, 8'h4D});
    key_step_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(12);
    checks++;
    if (obs_q.size() != 1 || bus.addr_out !== 8'h01) begin
      errors++;
      $display("FAIL bounce_one_write: reqs=%0d addr=%h want 1 01", obs_q.size(), bus.addr_out);
    end
    if (obs_q.size() == 1) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_txn: got %h want %h", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_read;
    txn_t e, o;
    cpu_state = ST_CHECK;
    addr_press(8'h10);
    @(negedge clk);
    exp_q.push_back(txn_t'{1'b0, 1'b1, 8'h10, 8'h00});
    key_step_n = 1'b0;
    cyc(7);
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL read_start: rd=%b wr=%b busy=%b want 1 0 1", bus.mem_rd, bus.mem_wr, bus.busy);
    end
    cyc(3);
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.addr_out !== 8'h11) begin
      errors++;
      $display("FAIL read_done: rd=%b addr=%h want 0 11", bus.mem_rd, bus.addr_out);
    end
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(10);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL read_count: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.wr !== e.wr || o.rd !== e.rd || o.addr !== e.addr) begin
        errors++;
        $display("FAIL read_txn: got %h want %h", o, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_both_keys;
    @(negedge clk);
    sw = 8'h77;
    key_addr_n = 1'b0;
    key_step_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_addr_n = 1'b1;
    key_step_n = 1'b1;
    cyc(10);
    checks++;
    if (bus.addr_out !== 8'h77 || obs_q.size() != 0 || bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL both_keys: addr=%h reqs=%0d rd=%b want 77 0 0", bus.addr_out, obs_q.size(), bus.mem_rd);
    end
    obs_q.delete();
  endtask

  task automatic test_busy_drop;
    txn_t e, o;
    cpu_state = ST_LOAD;
    ack_delay = 30;
    @(negedge clk);
    sw = 8'h12;
    exp_q.push_back(txn_t'{1'b1, 1'b0, 8'h77, 8'h12});
    key_step_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_step_n = 1'b1;
    sw = 8'h34;
    cyc(8);
    @(negedge clk);
    key_step_n = 1'b0;
    cyc(10);
    checks++;
    if (bus.busy !== 1'b1 || bus.data_out !== 8'h12) begin
      errors++;
      $display("FAIL busy_hold: busy=%b data=%h want 1 12", bus.busy, bus.data_out);
    end
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(25);
    ack_delay = 3;
    checks++;
    if (obs_q.size() != 1 || bus.addr_out !== 8'h78 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop: reqs=%0d addr=%h busy=%b want 1 78 0", obs_q.size(), bus.addr_out, bus.busy);
    end
    if (obs_q.size() == 1) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL busy_txn: got %h want %h", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_run_ignored;
    cpu_state = ST_RUN;
    @(negedge clk);
    sw = 8'h99;
    key_addr_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_addr_n = 1'b1;
    cyc(8);
    @(negedge clk);
    key_step_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(10);
    checks++;
    if (bus.addr_out !== 8'h78 || obs_q.size() != 0 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL run_ignored: addr=%h reqs=%0d wr=%b want 78 0 0", bus.addr_out, obs_q.size(), bus.mem_wr);
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset;
    txn_t e, o;
    cpu_state = ST_LOAD;
    @(negedge clk);
    sw = 8'hC3;
    exp_q.push_back(txn_t'{1'b1, 1'b0, 8'h78, 8'hC3});
    key_step_n = 1'b0;
    cyc(8);
    checks++;
    if (bus.mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_write: wr=%b want 1", bus.mem_wr);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.addr_out !== 8'h00 || bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: wr=%b busy=%b addr=%h data=%h want 0 0 00 00",
               bus.mem_wr, bus.busy, bus.addr_out, bus.data_out);
    end
    key_step_n = 1'b1;
    cyc(2);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL rst_abandoned_count: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL rst_abandoned_txn: got %h want %h", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
    cyc(3);
    @(negedge clk);
    sw = 8'hE7;
    exp_q.push_back(txn_t'{1'b1, 1'b0, 8'h00, 8'hE7});
    key_step_n = 1'b0;
    cyc(10);
    @(negedge clk);
    key_step_n = 1'b1;
    cyc(10);
    checks++;
    if (obs_q.size() != 1 || bus.addr_out !== 8'h01 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: reqs=%0d addr=%h wr=%b want 1 01 0", obs_q.size(), bus.addr_out, bus.mem_wr);
    end
    if (obs_q.size() == 1) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_recover_txn: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ack_delay  = 3;
    rst        = 1'b1;
    cpu_state  = ST_IDLE;
    sw         = 8'h00;
    key_addr_n = 1'b1;
    key_step_n = 1'b1;

    test_reset();
    test_addr_load();
    test_write_wrap();
    test_bounce();
    test_read();
    test_both_keys();
    test_busy_drop();
    test_run_ignored();
    test_async_reset();

    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: expected=%0d observed=%0d want 0 0", exp_q.size(), obs_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
